frog_move_ctrl: RTL and testbench
=================================

// Module: frog_move_ctrl
// PURPOSE
//  Parametrised player-control block for the grid game: edge-detected 4-way moves on a WxH tile grid,
//  lives, respawn delay, saturating score and a game-over state. Sits between the switch
//  inputs/collision detector and the renderer/score display. Owns frog position, score and lives.
// PARAMETERS
//  GRID_W       14        columns; X range 0..GRID_W-1
//  GRID_H       15        rows; Y range 0..GRID_H-1, row 0 = goal row
//  START_X      11        respawn column (< GRID_W)
//  START_Y      14        respawn row (< GRID_H)
//  TILE_W       4         width of tile code under frog
//  PAD_CODE     4         tile code of a lily pad
//  SCORE_W      7         score width; saturates at 2**SCORE_W-1
//  LIVES        3         lives at game start (1..7)
//  DEATH_TICKS  25000000  cycles spent in DYING before respawn (>=1)
//  RPT_TICKS    6250000   hold-repeat period (only with FROG_AUTO_REPEAT_EN)
// PORTS
//  i_Clk          in   1        system clock
//  i_Rst_L        in   1        synchronous reset, active low
//  i_Game_Active  in   1        level; 1 = game running, 0 = pause (state frozen)
//  i_Start        in   1        rising edge in IDLE/GAME_OVER starts a new game
//  i_Up_Mvt       in   1        up switch (level)
//  i_Down_Mvt     in   1        down switch
//  i_Left_Mvt     in   1        left switch
//  i_Right_Mvt    in   1        right switch
//  i_Collided     in   1        frog overlaps hazard this cycle
//  i_Tile_Data    in   TILE_W   tile code at current frog position
//  o_Frog_X       out  clog2(GRID_W)  frog column
//  o_Frog_Y       out  clog2(GRID_H)  frog row
//  o_Score        out  SCORE_W  score
//  o_Lives        out  3        remaining lives
//  o_State        out  3        FSM state code (package enum)
//  o_Score_Pulse  out  1        1-cycle pulse on pad reached
//  o_Death_Pulse  out  1        1-cycle pulse on life lost
// BEHAVIOUR
//  Reset (i_Rst_L=0 at edge): X=START_X, Y=START_Y, score=0, lives=LIVES, state=IDLE, pulses=0, edge regs=0.
//  FSM: IDLE -start-> PLAY; PLAY -collide/miss-> DYING; PLAY -pad-> SCORED; SCORED -1 cycle-> PLAY;
//   DYING -DEATH_TICKS elapsed, lives>0-> PLAY; DYING -elapsed, lives==0-> GAME_OVER; GAME_OVER -start-> PLAY.
//  Start from IDLE/GAME_OVER: score=0, lives=LIVES, frog at START; PLAY on next cycle.
//  Moves (PLAY only): rising edge = input high & previous sample low; position updates on that edge
//   (1-cycle latency). Priority up>down>left>right; one move per cycle. Clamp at 0 and GRID_x-1 (no wrap).
//  Collision in PLAY: wins over any move same cycle; lives-=1, o_Death_Pulse=1, frog to START, -> DYING.
//  Goal row: in PLAY with Y==0 and no collision: i_Tile_Data==PAD_CODE -> score+=1 (saturate),
//   o_Score_Pulse=1, frog to START, -> SCORED; else treated as collision (death path).
//  DYING: counter DEATH_TICKS-1 down to 0; moves/collisions ignored; lives==0 on entry -> GAME_OVER after delay.
//  i_Game_Active=0: all state, counters, position frozen; edge regs still sample (no spurious move on resume).
//  Lives decrement never underflows; o_Lives==0 only in DYING-to-GAME_OVER / GAME_OVER.
// CONFIGURATION
//  FROG_AUTO_REPEAT_EN defined: holding a direction repeats the move every RPT_TICKS cycles after the
//   first edge-triggered move; counter resets on release or direction change. Undefined: edge only, no repeat.
// STRUCTURE
//  frogger_pkg: state enum (IDLE,PLAY,DYING,SCORED,GAME_OVER), direction enum, PAD_CODE default.
//  Sub-module frog_btn_edge: 4-channel edge detector (+ repeat timer under FROG_AUTO_REPEAT_EN), outputs
//   one-hot move-request vector; FSM/position/score logic in frog_move_ctrl.
// TESTING (bench: GRID 14x15, START 11/14, DEATH_TICKS=4, LIVES=2, SCORE_W=3)
//  Reset then start; pulse up 3x -> Y=11, X=11; hold up 5 cycles (repeat off) -> only 1 move.
//  X=13, pulse right -> X stays 13; Y=14, pulse down -> stays 14; up+left same cycle -> only Y-1.
//  i_Collided with up press same cycle -> X=11,Y=14, lives 2->1, death pulse, PLAY after 4 cycles.
//  Reach Y=0 with tile=4 eight times -> score 1..7 then stays 7; tile=2 at Y=0 -> death path.
//  Lose both lives -> GAME_OVER, moves ignored; i_Start -> score 0, lives 2, PLAY.
//  i_Rst_L=0 mid-DYING -> IDLE, all outputs at reset values next cycle.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared types for the frog player-control block.
// Contents: FSM state enum, direction index enum, default lily-pad tile code, and a
// priority helper that keeps only the lowest set bit of a move vector.
package frogger_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPlay     = 3'd1,
    StDying    = 3'd2,
    StScored   = 3'd3,
    StGameOver = 3'd4
  } state_e;

  // Bit positions in the 4-bit move vectors; lower index wins.
  typedef enum logic [1:0] {
    DirUp    = 2'd0,
    DirDown  = 2'd1,
    DirLeft  = 2'd2,
    DirRight = 2'd3
  } dir_e;

  localparam int unsigned PadCodeDefault = 4;

  // Lowest set bit only: gives up > down > left > right.
  function automatic logic [3:0] prio_oh(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

endpackage

// File: rtl/frog_btn_edge.sv
// Four-channel rising-edge detector for the direction switches.
// Ports: i_Clk, i_Rst_L (sync, active low), i_Btn[3:0] (up, down, left, right levels),
//        o_Move_Req[3:0] one-hot move request (zero when no move this cycle).
// Macro FROG_AUTO_REPEAT_EN adds a hold-repeat timer firing every RPT_TICKS cycles.
// The edge registers sample every cycle, regardless of pause, so a switch held through
// a pause never produces a move on resume.
module frog_btn_edge
  import frogger_pkg::*;
#(
  parameter int unsigned RPT_TICKS = 6250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [3:0] i_Btn,
  output logic [3:0] o_Move_Req
);

  logic [3:0] r_prev;
  logic [3:0] w_rise;

  assign w_rise = i_Btn & ~r_prev;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) r_prev <= 4'b0;
    else          r_prev <= i_Btn;
  end

`ifdef FROG_AUTO_REPEAT_EN
  localparam int unsigned RptW = (RPT_TICKS > 1) ? $clog2(RPT_TICKS) : 1;

  logic [RptW-1:0] r_rpt_cnt;
  logic [RptW-1:0] w_rpt_cnt_d;
  logic [3:0]      w_hold;
  logic            w_rpt_fire;

  assign w_hold = prio_oh(i_Btn);

  // Count only while the same winning direction stays held; any change restarts.
  always_comb begin
    w_rpt_cnt_d = '0;
    w_rpt_fire  = 1'b0;
    if (w_hold != 4'b0 && w_hold == prio_oh(r_prev)) begin
      if (r_rpt_cnt == RptW'(RPT_TICKS - 1)) w_rpt_fire  = 1'b1;
      else                                   w_rpt_cnt_d = r_rpt_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) r_rpt_cnt <= '0;
    else          r_rpt_cnt <= w_rpt_cnt_d;
  end

  assign o_Move_Req = (w_rise != 4'b0) ? prio_oh(w_rise) : (w_rpt_fire ? w_hold : 4'b0);
`else
  assign o_Move_Req = prio_oh(w_rise);
`endif

endmodule

// File: rtl/frog_move_ctrl.sv
// Player control for the grid game: frog position, lives, respawn delay, saturating score
// and game-over handling.
// Ports: i_Clk, i_Rst_L (sync, active low), i_Game_Active (0 freezes state), i_Start (edge),
//        i_Up/Down/Left/Right_Mvt switch levels, i_Collided, i_Tile_Data (tile under frog);
//        o_Frog_X/Y position, o_Score, o_Lives, o_State (frogger_pkg::state_e code),
//        o_Score_Pulse / o_Death_Pulse one-cycle event flags.
// Macro FROG_AUTO_REPEAT_EN enables hold-repeat moves (see frog_btn_edge).
module frog_move_ctrl
  import frogger_pkg::*;
#(
  parameter int unsigned GRID_W      = 14,
  parameter int unsigned GRID_H      = 15,
  parameter int unsigned START_X     = 11,
  parameter int unsigned START_Y     = 14,
  parameter int unsigned TILE_W      = 4,
  parameter int unsigned PAD_CODE    = PadCodeDefault,
  parameter int unsigned SCORE_W     = 7,
  parameter int unsigned LIVES       = 3,
  parameter int unsigned DEATH_TICKS = 25000000,
  parameter int unsigned RPT_TICKS   = 6250000
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_L,
  input  logic                      i_Game_Active,
  input  logic                      i_Start,
  input  logic                      i_Up_Mvt,
  input  logic                      i_Down_Mvt,
  input  logic                      i_Left_Mvt,
  input  logic                      i_Right_Mvt,
  input  logic                      i_Collided,
  input  logic [TILE_W-1:0]         i_Tile_Data,
  output logic [$clog2(GRID_W)-1:0] o_Frog_X,
  output logic [$clog2(GRID_H)-1:0] o_Frog_Y,
  output logic [SCORE_W-1:0]        o_Score,
  output logic [2:0]                o_Lives,
  output logic [2:0]                o_State,
  output logic                      o_Score_Pulse,
  output logic                      o_Death_Pulse
);

  localparam int unsigned XW   = $clog2(GRID_W);
  localparam int unsigned YW   = $clog2(GRID_H);
  localparam int unsigned CntW = (DEATH_TICKS > 1) ? $clog2(DEATH_TICKS) : 1;

  state_e            r_state, w_state_d;
  logic [XW-1:0]     r_x, w_x_d;
  logic [YW-1:0]     r_y, w_y_d;
  logic [SCORE_W-1:0] r_score, w_score_d;
  logic [2:0]        r_lives, w_lives_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic              r_spulse, w_spulse_d;
  logic              r_dpulse, w_dpulse_d;
  logic              r_start_prev;
  logic              w_start_rise;
  logic [3:0]        w_move_req;

  frog_btn_edge #(
    .RPT_TICKS (RPT_TICKS)
  ) u_btn_edge (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_Btn      ({i_Right_Mvt, i_Left_Mvt, i_Down_Mvt, i_Up_Mvt}),
    .o_Move_Req (w_move_req)
  );

  assign w_start_rise = i_Start & ~r_start_prev;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_state      <= StIdle;
      r_x          <= XW'(START_X);
      r_y          <= YW'(START_Y);
      r_score      <= '0;
      r_lives      <= 3'(LIVES);
      r_cnt        <= '0;
      r_spulse     <= 1'b0;
      r_dpulse     <= 1'b0;
      r_start_prev <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_x          <= w_x_d;
      r_y          <= w_y_d;
      r_score      <= w_score_d;
      r_lives      <= w_lives_d;
      r_cnt        <= w_cnt_d;
      r_spulse     <= w_spulse_d;
      r_dpulse     <= w_dpulse_d;
      r_start_prev <= i_Start;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_x_d      = r_x;
    w_y_d      = r_y;
    w_score_d  = r_score;
    w_lives_d  = r_lives;
    w_cnt_d    = r_cnt;
    w_spulse_d = 1'b0;
    w_dpulse_d = 1'b0;
    if (i_Game_Active) begin
      unique case (r_state)
        StIdle, StGameOver: begin
          if (w_start_rise) begin
            w_state_d = StPlay;
            w_score_d = '0;
            w_lives_d = 3'(LIVES);
            w_x_d     = XW'(START_X);
            w_y_d     = YW'(START_Y);
          end
        end
        StPlay: begin
          // A goal-row tile that is not a pad counts as a collision.
          if (i_Collided || (r_y == '0 && i_Tile_Data != TILE_W'(PAD_CODE))) begin
            w_state_d  = StDying;
            w_lives_d  = (r_lives != 3'd0) ? r_lives - 3'd1 : 3'd0;
            w_dpulse_d = 1'b1;
            w_cnt_d    = CntW'(DEATH_TICKS - 1);
            w_x_d      = XW'(START_X);
            w_y_d      = YW'(START_Y);
          end else if (r_y == '0) begin
            w_state_d  = StScored;
            w_score_d  = (r_score == '1) ? r_score : r_score + 1'b1;
            w_spulse_d = 1'b1;
            w_x_d      = XW'(START_X);
            w_y_d      = YW'(START_Y);
          end else begin
            unique case (w_move_req)
              4'b0001: if (r_y != '0)                 w_y_d = r_y - 1'b1;
              4'b0010: if (r_y != YW'(GRID_H - 1))    w_y_d = r_y + 1'b1;
              4'b0100: if (r_x != '0)                 w_x_d = r_x - 1'b1;
              4'b1000: if (r_x != XW'(GRID_W - 1))    w_x_d = r_x + 1'b1;
              default: ;
            endcase
          end
        end
        StScored: w_state_d = StPlay;
        StDying: begin
          if (r_cnt == '0) w_state_d = (r_lives != 3'd0) ? StPlay : StGameOver;
          else             w_cnt_d   = r_cnt - 1'b1;
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  assign o_Frog_X      = r_x;
  assign o_Frog_Y      = r_y;
  assign o_Score       = r_score;
  assign o_Lives       = r_lives;
  assign o_State       = r_state;
  assign o_Score_Pulse = r_spulse;
  assign o_Death_Pulse = r_dpulse;

endmodule

// File: tb/tb_frog_move_ctrl.sv
module tb_frog_move_ctrl;

  localparam int SelX = 0, SelY = 1, SelScore = 2, SelLives = 3, SelState = 4;
  localparam int SelSp = 5, SelDp = 6;
  localparam int Idle = 0, Play = 1, Dying = 2, Scored = 3, GameOver = 4;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       active = 1'b1;
  logic       start = 1'b0;
  logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic       collided = 1'b0;
  logic [3:0] tile = 4'd4;
  logic [3:0] frog_x, frog_y;
  logic [2:0] score;
  logic [2:0] lives, state;
  logic       spulse, dpulse;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string tag;
    int    sel;
    int    exp;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  frog_move_ctrl #(
    .GRID_W      (14),
    .GRID_H      (15),
    .START_X     (11),
    .START_Y     (14),
    .TILE_W      (4),
    .PAD_CODE    (4),
    .SCORE_W     (3),
    .LIVES       (2),
    .DEATH_TICKS (4),
    .RPT_TICKS   (3)
  ) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_l),
    .i_Game_Active (active),
    .i_Start       (start),
    .i_Up_Mvt      (up),
    .i_Down_Mvt    (down),
    .i_Left_Mvt    (left),
    .i_Right_Mvt   (right),
    .i_Collided    (collided),
    .i_Tile_Data   (tile),
    .o_Frog_X      (frog_x),
    .o_Frog_Y      (frog_y),
    .o_Score       (score),
    .o_Lives       (lives),
    .o_State       (state),
    .o_Score_Pulse (spulse),
    .o_Death_Pulse (dpulse)
  );

  function automatic logic [31:0] observed(input int sel);
    case (sel)
      SelX:     return {28'b0, frog_x};
      SelY:     return {28'b0, frog_y};
      SelScore: return {29'b0, score};
      SelLives: return {29'b0, lives};
      SelState: return {29'b0, state};
      SelSp:    return {31'b0, spulse};
      default:  return {31'b0, dpulse};
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input int exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Pop every pending expectation and compare against the current DUT outputs.
  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      obs = observed(e.sel);
      n_checks++;
      assert (obs === 32'(e.exp)) else begin
        n_errors++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // dir: 0 up, 1 down, 2 left, 3 right
  task automatic press(input int dir);
    up = (dir == 0); down = (dir == 1); left = (dir == 2); right = (dir == 3);
    step(1);
    up = 0; down = 0; left = 0; right = 0;
    step(1);
  endtask

  initial begin
    // Reset values
    step(2);
    expect_val("rst_x", SelX, 11);
    expect_val("rst_y", SelY, 14);
    expect_val("rst_score", SelScore, 0);
    expect_val("rst_lives", SelLives, 2);
    expect_val("rst_state", SelState, Idle);
    expect_val("rst_sp", SelSp, 0);
    expect_val("rst_dp", SelDp, 0);
    drain();

    // Start
    rst_l = 1; start = 1;
    step(1);
    start = 0;
    expect_val("start_state", SelState, Play);
    expect_val("start_lives", SelLives, 2);
    drain();

    // Three up presses
    repeat (3) press(0);
    expect_val("up3_y", SelY, 11);
    expect_val("up3_x", SelX, 11);
    drain();

    // Held up is a single move with repeat disabled
    up = 1;
    step(5);
    up = 0;
    step(1);
    expect_val("hold_y", SelY, 10);
    drain();

    // Right clamp at 13
    press(3); press(3);
    expect_val("right_to13", SelX, 13);
    drain();
    press(3);
    expect_val("right_clamp", SelX, 13);
    drain();

    // Down clamp at 14
    repeat (4) press(1);
    expect_val("down_to14", SelY, 14);
    drain();
    press(1);
    expect_val("down_clamp", SelY, 14);
    drain();

    // Up and left together: up wins
    up = 1; left = 1;
    step(1);
    up = 0; left = 0;
    step(1);
    expect_val("upleft_y", SelY, 13);
    expect_val("upleft_x", SelX, 13);
    drain();

    // Collision beats a simultaneous up
    up = 1; collided = 1;
    step(1);
    up = 0; collided = 0;
    expect_val("col_x", SelX, 11);
    expect_val("col_y", SelY, 14);
    expect_val("col_lives", SelLives, 1);
    expect_val("col_dp", SelDp, 1);
    expect_val("col_state", SelState, Dying);
    drain();
    // Moves ignored while dying
    press(0);
    step(1);
    expect_val("dying_state", SelState, Dying);
    expect_val("dying_dp", SelDp, 0);
    expect_val("dying_y", SelY, 14);
    drain();
    step(1);
    expect_val("respawn_state", SelState, Play);
    drain();

    // Eight pad arrivals: 1..7 then saturate
    for (int k = 1; k <= 8; k++) begin
      repeat (14) press(0);
      expect_val("pad_score", SelScore, (k > 7) ? 7 : k);
      expect_val("pad_sp", SelSp, 1);
      expect_val("pad_state", SelState, Scored);
      expect_val("pad_y", SelY, 14);
      drain();
      step(1);
      expect_val("pad_back", SelState, Play);
      drain();
    end

    // Non-pad tile on goal row kills the last life
    tile = 4'd2;
    repeat (14) press(0);
    tile = 4'd4;
    expect_val("miss_state", SelState, Dying);
    expect_val("miss_lives", SelLives, 0);
    expect_val("miss_dp", SelDp, 1);
    drain();
    step(4);
    expect_val("go_state", SelState, GameOver);
    expect_val("go_lives", SelLives, 0);
    drain();
    press(0);
    expect_val("go_nomove", SelY, 14);
    expect_val("go_stay", SelState, GameOver);
    drain();

    // Restart
    start = 1;
    step(1);
    start = 0;
    expect_val("restart_score", SelScore, 0);
    expect_val("restart_lives", SelLives, 2);
    expect_val("restart_state", SelState, Play);
    drain();

    // Pause freezes; no spurious move on resume
    active = 0; up = 1;
    step(1);
    expect_val("pause_y", SelY, 14);
    drain();
    active = 1;
    step(1);
    expect_val("resume_y", SelY, 14);
    drain();
    up = 0;
    step(1);

    // Reset in the middle of DYING
    collided = 1;
    step(1);
    collided = 0;
    expect_val("pre_rst_state", SelState, Dying);
    drain();
    step(1);
    rst_l = 0;
    step(1);
    expect_val("mid_rst_state", SelState, Idle);
    expect_val("mid_rst_lives", SelLives, 2);
    expect_val("mid_rst_x", SelX, 11);
    expect_val("mid_rst_y", SelY, 14);
    expect_val("mid_rst_score", SelScore, 0);
    expect_val("mid_rst_dp", SelDp, 0);
    expect_val("mid_rst_sp", SelSp, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
